// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: registered N-input arbiter with runtime-selectable fixed-priority or
// round-robin winner selection, valid/ready grant handshake and grant hold under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req        level requests, bit k = requester k
//   rr_mode    0 = fixed priority (highest index wins), 1 = round-robin
//   out_ready  downstream accepts the current grant
//   out_valid  a grant is presented
//   out_idx    index of the granted requester (kept when out_valid=0)
//   grant      one-hot copy of out_idx, zero when out_valid=0
//   any_req    registered |req from the previous cycle
//   timeout    (ARB_TIMEOUT_EN only) one-cycle pulse when a held grant is abandoned
//
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a grant held for TIMEOUT cycles
// without acceptance is dropped and the stuck requester loses round-robin priority.
module prio_arbiter_rr #(
    parameter int unsigned N       = 8,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned IW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          rr_mode,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic [N-1:0]  grant,
`ifdef ARB_TIMEOUT_EN
    output logic          timeout,
`endif
    output logic          any_req
);

    if (N < 2) begin : g_bad_n
        $error("prio_arbiter_rr: N must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("prio_arbiter_rr: TIMEOUT must be >= 1");
    end

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic          any_req_q, any_req_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    logic          req_any;
    logic          handshake;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;

    assign req_any   = |req;
    assign handshake = (state_q == StHold) && out_ready;

    // On a handshake the pointer used for the next winner is the index just accepted,
    // so back-to-back grants already see the updated round-robin position.
    assign ptr = handshake ? out_idx_q : last_q;

    always_comb begin
        int unsigned k;
        win_idx = '0;
        k       = 0;
        if (!rr_mode) begin
            // Ascending scan: the last hit is the highest set index.
            for (int i = 0; i < int'(N); i++) begin
                if (req[i]) win_idx = IW'(i);
            end
        end else begin
            // Descending offset scan: the last hit is the nearest index after ptr.
            for (int unsigned off = N; off >= 1; off--) begin
                k = (32'(ptr) + off) % N;
                if (req[k[IW-1:0]]) win_idx = k[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        grant_d     = grant_q;
        last_d      = last_q;
        any_req_d   = req_any;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d     = StHold;
                    out_valid_d = 1'b1;
                    out_idx_d   = win_idx;
                    grant_d     = N'(1) << win_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StHold: begin
                if (out_ready) begin
                    last_d = out_idx_q;
                    if (req_any) begin
                        out_idx_d = win_idx;
                        grant_d   = N'(1) << win_idx;
`ifdef ARB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        grant_d     = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // This stalled cycle is the TIMEOUT-th one: abandon the grant.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    grant_d     = '0;
                    last_d      = out_idx_q;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            grant_q     <= '0;
            last_q      <= IW'(N - 1);
            any_req_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            any_req_q   <= any_req_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign grant     = grant_q;
    assign any_req   = any_req_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Self-checking bench for prio_arbiter_rr (N=4): directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the arbitration rules.
module tb_prio_arbiter_rr;

    localparam int N  = 4;
    localparam int IW = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int TO       = 4;
    localparam int HOLD_CYC = 3;
`else
    localparam int TO       = 16;
    localparam int HOLD_CYC = 5;
`endif

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          rr_mode;
    logic          out_ready;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic [N-1:0]  grant;
    logic          any_req;
    logic          timeout;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_last;
    int m_cnt;
    bit m_to;
    bit m_any;

    prio_arbiter_rr #(
        .N       (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_mode   (rr_mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .grant     (grant),
`ifdef ARB_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .any_req   (any_req)
    );

`ifndef ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [N-1:0] r, input bit rr, input int last);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int d = 1; d <= N; d++) if (r[(last + d) % N]) return (last + d) % N;
        end
        return 0;
    endfunction

    // Apply the arbitration rules for one rising edge using the inputs held across it.
    task automatic model_edge();
        if (!rst_n) begin
            m_valid = 0; m_idx = 0; m_last = N - 1; m_cnt = 0; m_to = 0; m_any = 0;
        end else begin
            m_to = 0;
            if (!m_valid) begin
                if (req != 0) begin
                    m_idx = pick_winner(req, rr_mode, m_last); m_valid = 1; m_cnt = 0;
                end
            end else if (out_ready) begin
                m_last = m_idx;
                if (req != 0) begin
                    m_idx = pick_winner(req, rr_mode, m_last); m_cnt = 0;
                end else begin
                    m_valid = 0;
                end
            end else begin
`ifdef ARB_TIMEOUT_EN
                m_cnt++;
                if (m_cnt == TO) begin
                    m_valid = 0; m_last = m_idx; m_to = 1;
                end
`endif
            end
            m_any = (req != 0);
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_grant;
        @(posedge clk);
        model_edge();
        #1;
        exp_grant = m_valid ? N'(1) << m_idx : '0;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_idx",   32'(out_idx),   32'(m_idx));
        check_eq("grant",     32'(grant),     32'(exp_grant));
        check_eq("any_req",   32'(any_req),   32'(m_any));
        check_eq("timeout",   32'(timeout),   32'(m_to));
    endtask

    initial begin
        int rr_seq[5];
        int alt_seq[4];
        rr_seq  = '{0, 1, 2, 3, 0};
        alt_seq = '{1, 3, 1, 3};
        m_valid = 0; m_idx = 0; m_last = N - 1; m_cnt = 0; m_to = 0; m_any = 0;
        rst_n = 1'b0; req = 4'b1111; rr_mode = 1'b1; out_ready = 1'b1;

        // Reset with all requests active, then round-robin rotation
        step(); step();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_idx",   32'(out_idx),   32'd0);
        check_eq("rst_grant", 32'(grant),     32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("rr_seq_valid", 32'(out_valid), 32'd1);
            check_eq("rr_seq_idx",   32'(out_idx),   32'(rr_seq[i]));
        end
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rr_alt_idx", 32'(out_idx), 32'(alt_seq[i]));
        end

        // Fixed priority, then requests drop
        rr_mode = 1'b0; req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fix_idx",   32'(out_idx), 32'd2);
            check_eq("fix_grant", 32'(grant),   32'b0100);
        end
        req = 4'b0000;
        step();
        check_eq("drop_valid", 32'(out_valid), 32'd0);
        check_eq("drop_grant", 32'(grant),     32'd0);
        check_eq("drop_idx",   32'(out_idx),   32'd2);

        // Grant hold under backpressure while req changes
        out_ready = 1'b0; req = 4'b0010;
        step();
        req = 4'b1000;
        for (int i = 0; i < HOLD_CYC; i++) begin
            step();
            check_eq("hold_idx",   32'(out_idx), 32'd1);
            check_eq("hold_grant", 32'(grant),   32'b0010);
        end
        out_ready = 1'b1;
        step();
        check_eq("after_hold_idx", 32'(out_idx), 32'd3);

        // Reset in the middle of a held grant restores the pointer
        req = 4'b0000; step();
        rr_mode = 1'b1; out_ready = 1'b0; req = 4'b0100;
        step(); step();
        check_eq("pre_rst_idx", 32'(out_idx), 32'd2);
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_grant", 32'(grant),     32'd0);
        rst_n = 1'b1; req = 4'b1111;
        step();
        check_eq("post_rst_idx", 32'(out_idx), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Timeout abandons a stuck grant and rotates priority
        rst_n = 1'b0; step();
        rst_n = 1'b1; rr_mode = 1'b1; req = 4'b0011; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("to_hold_idx", 32'(out_idx), 32'd0);
            check_eq("to_hold_v",   32'(out_valid), 32'd1);
        end
        step();
        check_eq("to_valid", 32'(out_valid), 32'd0);
        check_eq("to_pulse", 32'(timeout),   32'd1);
        step();
        check_eq("to_next_idx", 32'(out_idx), 32'd1);
        check_eq("to_clear",    32'(timeout), 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            req       = N'($urandom);
            if ($urandom_range(0, 7) == 0) req = '0;
            rr_mode   = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 59) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
